// File: rtl/scc_fetch_unit.sv
// scc_fetch_unit: SCC instruction fetch (PC, 1-cycle imem reads, FIFO to decode, redirect/halt/error).
// Define SCC_FETCH_PERF_EN to add the perf_fetch_cnt / perf_bubble_cnt counters.
module scc_fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_v,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_f,
    output logic              inst_v,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_rdy,
`ifdef SCC_FETCH_PERF_EN
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_bubble_cnt,
    output logic              fetch_err
`else
    output logic              fetch_err
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {RUN, HALTED, ERR} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q, ipc_q;
    logic              inflight_q, fetch_err_q;
    logic [DATA_W-1:0] data_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] tag_q [FIFO_DEPTH];
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW:0]       occ;
    logic              pop, push, misalign;

    always_comb begin
        inst_v    = cnt_q != '0;
        inst      = inst_v ? data_q[rptr_q] : '0;
        inst_pc   = inst_v ? tag_q[rptr_q] : '0;
        pop       = inst_v & inst_rdy & clk_en & ~redirect_v;
        push      = inflight_q & clk_en & ~redirect_v;
        occ       = {1'b0, cnt_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
        imem_req  = ~rst & clk_en & (state_q == RUN) & ~redirect_v & ~halt_f &
                    (occ < (CW+1)'(FIFO_DEPTH));
        imem_addr = pc_q;
        fetch_err = fetch_err_q;
        misalign  = redirect_pc[1:0] != 2'b00;
        cnt_d     = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            ipc_q       <= '0;
            inflight_q  <= 1'b0;
            fetch_err_q <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
        end else if (clk_en) begin
            // No request is issued during a redirect, so clearing inflight drops the next-cycle response.
            inflight_q <= imem_req;
            if (imem_req) begin
                ipc_q <= pc_q;
                pc_q  <= pc_q + ADDR_W'(4);
            end
            if (redirect_v) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
                if (!misalign)
                    pc_q <= redirect_pc;
                else if (state_q == RUN) begin
                    fetch_err_q <= 1'b1;
                    state_q     <= ERR;
                end
            end else begin
                if (push) begin
                    data_q[wptr_q] <= imem_rdata;
                    tag_q[wptr_q]  <= ipc_q;
                    wptr_q         <= wptr_q + PW'(1);
                end
                if (pop)
                    rptr_q <= rptr_q + PW'(1);
                cnt_q <= cnt_d;
            end
            if (state_q == RUN && halt_f && !(redirect_v && misalign))
                state_q <= HALTED;
        end
    end

`ifdef SCC_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else if (clk_en) begin
            perf_fetch_cnt  <= perf_fetch_cnt + 32'(pop);
            perf_bubble_cnt <= perf_bubble_cnt + 32'(state_q == RUN && !inst_v);
        end
    end
`endif
endmodule

// File: tb/tb_scc_fetch_unit.sv
// tb_scc_fetch_unit: directed checks of fetch stream, backpressure, redirect, error, halt and clk_en.
module tb_scc_fetch_unit;
    logic        clk = 1'b0, rst, clk_en, imem_req, redirect_v, halt_f, inst_v, inst_rdy, fetch_err;
    logic [31:0] imem_addr, redirect_pc, inst, inst_pc;
    logic [31:0] imem_rdata = '0;
`ifdef SCC_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
`endif
    int errors = 0, checks = 0;

    scc_fetch_unit dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_v(redirect_v), .redirect_pc(redirect_pc), .halt_f(halt_f),
        .inst_v(inst_v), .inst(inst), .inst_pc(inst_pc), .inst_rdy(inst_rdy),
`ifdef SCC_FETCH_PERF_EN
        .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt),
`endif
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    // imem: returns addr>>2 one cycle after the request, frozen while clk_en=0
    always @(posedge clk) if (clk_en && imem_req) imem_rdata <= imem_addr >> 2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        redirect_v = 1'b0;
        halt_f = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick;
            #1;
            check("rst_req", imem_req, 0);
            check("rst_v", inst_v, 0);
            check("rst_inst", inst, 0);
            check("rst_pc", inst_pc, 0);
            check("rst_err", fetch_err, 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        clk_en = 1'b1;
        inst_rdy = 1'b1;
        redirect_pc = '0;
        do_reset(3);
        // stream from reset: first inst_v in cycle 2
        for (int k = 0; k < 10; k++) begin
            #1;
            check("t1_req", imem_req, 1);
            check("t1_addr", imem_addr, 4 * k);
            check("t1_v", inst_v, k >= 2);
            check("t1_inst", inst, k >= 2 ? k - 2 : 0);
            check("t1_ipc", inst_pc, k >= 2 ? 4 * (k - 2) : 0);
            tick;
        end
        // backpressure: head word 8 held, FIFO fills to 2, no requests
        inst_rdy = 1'b0;
        for (int j = 0; j < 5; j++) begin
            #1;
            check("t2_req", imem_req, 0);
            check("t2_v", inst_v, 1);
            check("t2_inst", inst, 8);
            check("t2_ipc", inst_pc, 32);
            tick;
        end
        inst_rdy = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            if (j == 0) check("t2_resume", imem_addr, 40);
            check("t2_rel_inst", inst, 8 + j);
            check("t2_rel_ipc", inst_pc, 4 * (8 + j));
            tick;
        end
        // stall one cycle to fill FIFO, then redirect to 0x100
        inst_rdy = 1'b0;
        #1;
        check("t3_stall_req", imem_req, 0);
        check("t3_stall_inst", inst, 12);
        tick;
        inst_rdy = 1'b1;
        redirect_v = 1'b1;
        redirect_pc = 32'h100;
        #1;
        check("t3_rd_req", imem_req, 0);
        check("t3_rd_inst", inst, 12);
        tick;
        redirect_v = 1'b0;
        #1;
        check("t3_flush_v", inst_v, 0);
        check("t3_addr0", imem_addr, 32'h100);
        check("t3_req0", imem_req, 1);
        tick;
        #1;
        check("t3_flush_v2", inst_v, 0);
        check("t3_addr1", imem_addr, 32'h104);
        tick;
        for (int j = 0; j < 2; j++) begin
            #1;
            check("t3_inst", inst, 32'h40 + j);
            check("t3_ipc", inst_pc, 32'h100 + 4 * j);
            tick;
        end
        // halt with 1 buffered + 1 inflight
        halt_f = 1'b1;
        #1;
        check("t5_req", imem_req, 0);
        check("t5_inst0", inst, 32'h42);
        check("t5_ipc0", inst_pc, 32'h108);
        tick;
        #1;
        check("t5_inst1", inst, 32'h43);
        check("t5_ipc1", inst_pc, 32'h10c);
        check("t5_req1", imem_req, 0);
        tick;
        for (int j = 0; j < 4; j++) begin
            #1;
            check("t5_idle_v", inst_v, 0);
            check("t5_idle_req", imem_req, 0);
            tick;
        end
        halt_f = 1'b0;
        #1;
        check("t5_sticky", imem_req, 0);
        tick;
        // redirect and halt together: PC loaded, nothing fetched
        do_reset(1);
        redirect_v = 1'b1;
        redirect_pc = 32'h200;
        halt_f = 1'b1;
        #1;
        check("t5b_req", imem_req, 0);
        tick;
        redirect_v = 1'b0;
        halt_f = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            check("t5b_req_idle", imem_req, 0);
            check("t5b_v", inst_v, 0);
            check("t5b_pc", imem_addr, 32'h200);
            tick;
        end
        // misaligned redirect -> sticky error
        do_reset(1);
        #1;
        check("t4_req0", imem_req, 1);
        tick;
        tick;
        #1;
        check("t4_pre_inst", inst, 0);
        check("t4_pre_v", inst_v, 1);
        redirect_v = 1'b1;
        redirect_pc = 32'h102;
        #1;
        check("t4_rd_req", imem_req, 0);
        check("t4_pre_err", fetch_err, 0);
        tick;
        redirect_v = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            check("t4_err", fetch_err, 1);
            check("t4_req", imem_req, 0);
            check("t4_v", inst_v, 0);
            check("t4_pc", imem_addr, 8);
            tick;
        end
        redirect_v = 1'b1;
        redirect_pc = 32'h300;
        tick;
        redirect_v = 1'b0;
        #1;
        check("t4_err_hold", fetch_err, 1);
        check("t4_req_hold", imem_req, 0);
        // reset clears error; reset mid-flight discards pending response
        do_reset(1);
        #1;
        check("t4_clr_err", fetch_err, 0);
        check("t4_clr_addr", imem_addr, 0);
        tick;
        do_reset(1);
        #1;
        check("mr_v0", inst_v, 0);
        check("mr_addr0", imem_addr, 0);
        tick;
        #1;
        check("mr_v1", inst_v, 0);
        tick;
        #1;
        check("mr_v2", inst_v, 1);
        check("mr_inst", inst, 0);
        check("mr_ipc", inst_pc, 0);
        // clk_en toggling: same stream at half rate
        do_reset(1);
        for (int c = 0; c < 20; c++) begin
            int m;
            clk_en = (c % 2) == 0;
            m = (c + 1) / 2;
            #1;
            check("t6_req", imem_req, clk_en);
            check("t6_addr", imem_addr, 4 * m);
            check("t6_v", inst_v, m >= 2);
            check("t6_inst", inst, m >= 2 ? m - 2 : 0);
            tick;
        end
        clk_en = 1'b1;
        #1;
        check("t6_end_inst", inst, 8);
`ifdef SCC_FETCH_PERF_EN
        check("perf_fetch", perf_fetch_cnt, 8);
        check("perf_bubble", perf_bubble_cnt, 2);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
